// File: rtl/traffic_phase_scheduler.sv
// Signal-phase sequencer for one intersection: min-green / yellow / all-red timing,
// decision-epoch step strobe and episode step counter. Optional macro: TRAFFIC_PHASE_ALLRED_EN.
module traffic_phase_scheduler #(
    parameter int GREEN_MIN   = 4,
    parameter int YELLOW_T    = 2,
    parameter int ALLRED_T    = 1,
    parameter int EPISODE_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_learning,
    input  logic       i_act_valid,
    input  logic [1:0] i_act,
    output logic       o_act_ready,
    output logic [1:0] o_phase_out,
    output logic       o_phase_valid,
    output logic       o_yellow,
    output logic       o_allred,
    output logic       o_step,
    output logic [7:0] o_step_cnt,
    output logic       o_episode_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } state_t;

    // One shared timer serves the green minimum and both clearance intervals.
    localparam int TMAX_A = (GREEN_MIN > YELLOW_T) ? GREEN_MIN : YELLOW_T;
    localparam int TMAX   = (TMAX_A > ALLRED_T) ? TMAX_A : ALLRED_T;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
    localparam logic [7:0]    STEP_LAST   = 8'(EPISODE_LEN - 1);

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [1:0]      r_pending;
    logic [1:0]      r_phase;
    logic            r_phase_valid;
    logic            r_yellow;
    logic            r_allred;
    logic            r_step;
    logic [7:0]      r_step_cnt;
    logic            r_episode_done;

    state_t          w_state_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic [1:0]      w_pending_nxt;
    logic [1:0]      w_phase_nxt;
    logic            w_step_nxt;
    logic [7:0]      w_step_cnt_nxt;
    logic            w_episode_done_nxt;
    logic            w_accept;

    assign o_act_ready = (r_state == IDLE) || ((r_state == GREEN) && (r_timer == GREEN_LAST));
    assign w_accept    = i_act_valid && o_act_ready;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_pending_nxt = r_pending;
        w_phase_nxt   = r_phase;
        w_step_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_phase_nxt = i_act;
                    w_state_nxt = GREEN;
                    w_timer_nxt = '0;
                    w_step_nxt  = 1'b1;
                end
            end
            GREEN: begin
                if (w_accept) begin
                    w_timer_nxt = '0;
                    if (i_act == r_phase) begin
                        w_step_nxt = 1'b1;
                    end else begin
                        w_pending_nxt = i_act;
                        w_state_nxt   = YELLOW;
                    end
                end else if (r_timer != GREEN_LAST) begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            YELLOW: begin
                if (r_timer == YELLOW_LAST) begin
                    w_timer_nxt = '0;
`ifdef TRAFFIC_PHASE_ALLRED_EN
                    w_state_nxt = ALLRED;
`else
                    w_state_nxt = GREEN;
                    w_phase_nxt = r_pending;
                    w_step_nxt  = 1'b1;
`endif
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
`ifdef TRAFFIC_PHASE_ALLRED_EN
            ALLRED: begin
                if (r_timer == TW'(ALLRED_T - 1)) begin
                    w_timer_nxt = '0;
                    w_state_nxt = GREEN;
                    w_phase_nxt = r_pending;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Episode bookkeeping rides on the same step that is being generated this cycle.
    always_comb begin
        w_step_cnt_nxt     = r_step_cnt;
        w_episode_done_nxt = 1'b0;
        if (w_step_nxt && i_learning) begin
            if (r_step_cnt == STEP_LAST) begin
                w_step_cnt_nxt     = '0;
                w_episode_done_nxt = 1'b1;
            end else begin
                w_step_cnt_nxt = r_step_cnt + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_timer        <= '0;
            r_pending      <= '0;
            r_phase        <= '0;
            r_phase_valid  <= 1'b0;
            r_yellow       <= 1'b0;
            r_allred       <= 1'b0;
            r_step         <= 1'b0;
            r_step_cnt     <= '0;
            r_episode_done <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_timer        <= w_timer_nxt;
            r_pending      <= w_pending_nxt;
            r_phase        <= w_phase_nxt;
            r_phase_valid  <= (w_state_nxt == GREEN);
            r_yellow       <= (w_state_nxt == YELLOW);
            r_allred       <= (w_state_nxt == ALLRED);
            r_step         <= w_step_nxt;
            r_step_cnt     <= w_step_cnt_nxt;
            r_episode_done <= w_episode_done_nxt;
        end
    end

    assign o_phase_out    = r_phase;
    assign o_phase_valid  = r_phase_valid;
    assign o_yellow       = r_yellow;
    assign o_step         = r_step;
    assign o_step_cnt     = r_step_cnt;
    assign o_episode_done = r_episode_done;
`ifdef TRAFFIC_PHASE_ALLRED_EN
    assign o_allred       = r_allred;
`else
    assign o_allred       = 1'b0;
`endif

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Sequences signal phases for one intersection of the traffic environment. It accepts action requests from the Q-learning agent through a valid/ready handshake and enforces minimum green, yellow and all-red intervals. It emits the applied action plus a one-cycle `step` strobe that advances the state converter exactly once per decision epoch. It also counts steps per learning episode. Instantiate one per intersection (A and B).

## Interface
- `GREEN_MIN`, 4: minimum green cycles before a new action is accepted (≥1).
- `YELLOW_T`, 2: yellow interval cycles on a phase change (≥1).
- `ALLRED_T`, 1: all-red interval cycles after yellow (≥1; used only with the macro).
- `EPISODE_LEN`, 64: steps per learning episode (2..256).

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `learning` in 1: agent in learning mode; enables episode counting.
- `act_valid` in 1: agent presents an action.
- `act` in 2: requested phase 0..3.
- `act_ready` out 1: scheduler accepts `act` this cycle.
- `phase_out` out 2: applied action to the state converter.
- `phase_valid` out 1: high while in GREEN.
- `yellow` out 1: high during the yellow interval.
- `allred` out 1: high during the all-red interval.
- `step` out 1: one-cycle decision-epoch strobe; state converter update enable.
- `step_cnt` out 8: steps taken in the current episode.
- `episode_done` out 1: one-cycle pulse on the last step of an episode.

## Operation
- FSM states: IDLE, GREEN, YELLOW, ALLRED.
- Reset values: state IDLE, `phase_out`=0, `phase_valid`=0, `yellow`=0, `allred`=0, `step`=0, `step_cnt`=0, `episode_done`=0, internal timers 0.
- Reset applies from any state, mid-interval included. The next cycle shows reset values.
- IDLE:
  - `act_ready`=1.
  - On accept: `phase_out`←`act`, go to GREEN, pulse `step`.
- GREEN:
  - `green_cnt` clears on entry and increments, saturating at `GREEN_MIN`-1.
  - `act_ready` = (`green_cnt` == `GREEN_MIN`-1).
  - With no accept, green holds indefinitely.
  - Accept with `act`==`phase_out` (extension): stay in GREEN, clear `green_cnt`, pulse `step`.
  - Accept with a different `act`: latch it as pending, go to YELLOW.
- YELLOW:
  - `yellow`=1, `phase_out` holds the old phase, `act_ready`=0.
  - After `YELLOW_T` cycles, go to ALLRED.
- ALLRED:
  - `allred`=1, `act_ready`=0.
  - After `ALLRED_T` cycles: `phase_out`←pending, go to GREEN, pulse `step`.
- `act_ready` is combinational from state and timer only. It never depends on `act_valid`.
- Every `step` pulse: if `learning`=1, `step_cnt` increments.
  - When `step_cnt`==`EPISODE_LEN`-1, that same step also pulses `episode_done` and wraps `step_cnt` to 0.
- With `learning`=0: `step_cnt` holds and `episode_done` stays 0. `step` still pulses.

## Timing
- All outputs are registered except `act_ready`.
- Handshake accept occurs in cycle N (`act_valid`&&`act_ready`).
- From IDLE, or an extension: `step`=1 and the new `phase_out` appear in cycle N+1.
- Phase change:
  - `yellow`=1 in N+1..N+`YELLOW_T`.
  - `allred`=1 in the next `ALLRED_T` cycles.
  - `step`, `phase_valid` and the new `phase_out` appear in cycle N+`YELLOW_T`+`ALLRED_T`+1.
- Green entered in cycle G: `act_ready` is first high in G+`GREEN_MIN`-1. With `GREEN_MIN`=1 it is high in G itself.
- A held `act_valid` is accepted only once per epoch, because ready drops after accept.
- `episode_done` is coincident with the `step` that ends the episode.

## Configuration
- `TRAFFIC_PHASE_ALLRED_EN` defined: ALLRED state is present as described.
- Not defined: YELLOW goes directly to GREEN.
  - `allred` is tied 0.
  - `ALLRED_T` is ignored.
  - Phase-change latency is N+`YELLOW_T`+1.

## Test plan
- Reset then `act`=2 valid at cycle 5 → `step` and `phase_out`=2 at cycle 6. `act_ready` low in 6..8, high at 9 (defaults).
- In GREEN with phase 2, accept `act`=2 → `step` next cycle, `yellow` never asserted, `act_ready` low for 3 cycles.
- In GREEN with phase 2, accept `act`=1 at N → `yellow` N+1..N+2, `allred` N+3, `step` and `phase_out`=1 at N+4. Without the macro: `step` at N+3, `allred`=0 throughout.
- `EPISODE_LEN`=4, `learning`=1, four accepted extensions → `step_cnt` 1,2,3,0, with `episode_done` on the fourth `step` only. With `learning`=0: `step_cnt` frozen, no `episode_done`.
- Assert `rst` during YELLOW → next cycle all outputs at reset values, `act_ready`=1. The next action is accepted from IDLE with no pending phase applied.
